// File: rtl/seg7_scan_driver_if.sv
// Display bus between a digit source and the scan driver: the per-digit
// input fields and the multiplexed pin-level outputs.
// No handshake: the driver samples the input fields every clock, and the
// outputs are always valid once reset is released.
interface seg7_scan_driver_if #(
  parameter int DIGITS = 8
);
  logic [4*DIGITS-1:0] digits;
  logic [DIGITS-1:0]   dp;
  logic [DIGITS-1:0]   blank;
  logic [DIGITS-1:0]   blink;
  logic [DIGITS-1:0]   an;
  logic [7:0]          segment;
  logic                frame_tick;

  modport master (
    output digits, dp, blank, blink,
    input  an, segment, frame_tick
  );

  modport slave (
    input  digits, dp, blank, blink,
    output an, segment, frame_tick
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver: scans DIGITS nibbles onto one shared
// active-low segment bus with active-low digit enables. Each slot opens
// with GUARD dark cycles so the previous digit's pattern cannot ghost onto
// the next anode. It also handles optional hex glyphs, per-digit decimal
// point, blanking and frame-based blinking.
module seg7_scan_driver #(
  parameter int DIGITS       = 8,
  parameter int SCAN_DIV     = 100000,
  parameter int GUARD        = 2,
  parameter int BLINK_FRAMES = 64,
  parameter int HEX_MODE     = 0
) (
  input logic               clk,
  input logic               rst,
  seg7_scan_driver_if.slave bus
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0]     presc_q, presc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [FW-1:0]     frame_cnt_q, frame_cnt_d;
  logic              blink_phase_q, blink_phase_d;
  logic              frame_tick_q, frame_tick_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [7:0]        seg_q, seg_d;
  logic [3:0]        nib;

  // Codes 10..15 are blank unless hex glyphs are enabled.
  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g;
    g = 7'h7F;
    case (v)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = (HEX_MODE != 0) ? 7'h08 : 7'h7F;
      4'hB: g = (HEX_MODE != 0) ? 7'h03 : 7'h7F;
      4'hC: g = (HEX_MODE != 0) ? 7'h46 : 7'h7F;
      4'hD: g = (HEX_MODE != 0) ? 7'h21 : 7'h7F;
      4'hE: g = (HEX_MODE != 0) ? 7'h06 : 7'h7F;
      4'hF: g = (HEX_MODE != 0) ? 7'h0E : 7'h7F;
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

  // Slot timing: prescaler, digit index, frame counter and blink phase.
  always_comb begin
    presc_d       = presc_q + PW'(1);
    idx_d         = idx_q;
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    frame_tick_d  = 1'b0;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d        = '0;
        frame_tick_d = 1'b1;
        if (frame_cnt_q == FRAME_LAST) begin
          frame_cnt_d   = '0;
          blink_phase_d = ~blink_phase_q;
        end else begin
          frame_cnt_d = frame_cnt_q + FW'(1);
        end
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end
  end

  // Pin patterns are based on the post-update slot position, so the
  // registered outputs line up with the slot the counters have just entered.
  always_comb begin
    nib  = bus.digits[{idx_d, 2'b00} +: 4];
    an_d = '1;
    seg_d = 8'hFF;
    if (int'(presc_d) >= GUARD) begin
      an_d[idx_d] = 1'b0;
      if (!bus.blank[idx_d] && !(bus.blink[idx_d] && blink_phase_d)) begin
        seg_d = {~bus.dp[idx_d], glyph(nib)};
      end
    end
  end

  // State and output registers; reset darkens the display immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q       <= '0;
      idx_q         <= '0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      frame_tick_q  <= 1'b0;
      an_q          <= '1;
      seg_q         <= 8'hFF;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      frame_tick_q  <= frame_tick_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.segment    = seg_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver. Three instances share one clock and
// one reset:
//   a: 4 digits, SCAN_DIV=4, GUARD=1, BLINK_FRAMES=2, decimal glyphs
//   b: same as a, hex glyphs
//   c: 1 digit, SCAN_DIV=2, GUARD=0, hex glyphs
module tb_seg7_scan_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  // Expected lit segment codes for digits 4321 with dp off (digit 0 first).
  logic [7:0] seg_4321 [4] = '{8'hF9, 8'hA4, 8'hB0, 8'h99};
  // Glyph table bits [6:0] with hex glyphs enabled.
  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                               7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                               7'h46, 7'h21, 7'h06, 7'h0E};

  seg7_scan_driver_if #(.DIGITS(4)) a_if ();
  seg7_scan_driver_if #(.DIGITS(4)) b_if ();
  seg7_scan_driver_if #(.DIGITS(1)) c_if ();

  seg7_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .GUARD(1), .BLINK_FRAMES(2), .HEX_MODE(0))
    u_a (.clk(clk), .rst(rst), .bus(a_if));
  seg7_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .GUARD(1), .BLINK_FRAMES(2), .HEX_MODE(1))
    u_b (.clk(clk), .rst(rst), .bus(b_if));
  seg7_scan_driver #(.DIGITS(1), .SCAN_DIV(2), .GUARD(0), .BLINK_FRAMES(1), .HEX_MODE(1))
    u_c (.clk(clk), .rst(rst), .bus(c_if));

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_a_an"},  32'(a_if.an), 32'hF);
    check({tag, "_a_seg"}, 32'(a_if.segment), 32'hFF);
    check({tag, "_a_ft"},  32'(a_if.frame_tick), 32'h0);
    check({tag, "_c_an"},  32'(c_if.an), 32'h1);
    check({tag, "_c_seg"}, 32'(c_if.segment), 32'hFF);
  endtask

  initial begin
    logic [3:0] exp_an;
    logic [7:0] exp_seg;
    logic [3:0] cnib;
    int p, i, f;

    a_if.digits = 16'h4321; a_if.dp = '0; a_if.blank = '0; a_if.blink = '0;
    b_if.digits = 16'h4321; b_if.dp = '0; b_if.blank = '0; b_if.blink = '0;
    c_if.digits = 4'h5;     c_if.dp = '0; c_if.blank = '0; c_if.blink = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_state("reset");

    // Basic scan of 4321: two full frames.
    for (int c = 1; c <= 32; c++) begin
      tick();
      p = c % 4;
      i = (c / 4) % 4;
      exp_an  = (p == 0) ? 4'hF : ~(4'b0001 << i);
      exp_seg = (p == 0) ? 8'hFF : seg_4321[i];
      check($sformatf("scan_an_c%0d", c),  32'(a_if.an), 32'(exp_an));
      check($sformatf("scan_seg_c%0d", c), 32'(a_if.segment), 32'(exp_seg));
      check($sformatf("scan_ft_c%0d", c),  32'(a_if.frame_tick), 32'((c % 16) == 0));
      check($sformatf("c_an_c%0d", c),     32'(c_if.an), 32'h0);
      check($sformatf("c_seg_c%0d", c),    32'(c_if.segment), 32'h92);
      check($sformatf("c_ft_c%0d", c),     32'(c_if.frame_tick), 32'((c % 2) == 0));
    end

    // Code 0xA on digit 0: blank vs hex glyph, then with dp on.
    a_if.digits = 16'h432A; b_if.digits = 16'h432A;
    tick(); // c=33, digit 0 lit
    check("hexA_a_an",  32'(a_if.an), 32'hE);
    check("hexA_a_seg", 32'(a_if.segment), 32'hFF);
    check("hexA_b_seg", 32'(b_if.segment), 32'h88);
    a_if.dp = 4'b0001; b_if.dp = 4'b0001;
    tick(); // c=34
    check("hexA_dp_a_seg", 32'(a_if.segment), 32'h7F);
    check("hexA_dp_b_seg", 32'(b_if.segment), 32'h08);

    // Blank digit 1 overrides its decimal point.
    a_if.digits = 16'h8888; a_if.dp = 4'b0010; a_if.blank = 4'b0010;
    for (int c = 35; c <= 47; c++) begin
      tick();
      p = c % 4;
      i = (c / 4) % 4;
      exp_an  = (p == 0) ? 4'hF : ~(4'b0001 << i);
      exp_seg = (p == 0 || i == 1) ? 8'hFF : 8'h80;
      check($sformatf("blank_an_c%0d", c),  32'(a_if.an), 32'(exp_an));
      check($sformatf("blank_seg_c%0d", c), 32'(a_if.segment), 32'(exp_seg));
    end

    // Asynchronous reset in the middle of digit 3's lit slot.
    #2;
    rst = 1'b1;
    #1;
    check_reset_state("async_rst");
    @(posedge clk);
    @(negedge clk);
    a_if.digits = 16'h0000; a_if.dp = '0; a_if.blank = '0; a_if.blink = 4'b0001;
    rst = 1'b0;
    #1;
    check_reset_state("release");

    // Blink on digit 0 over five frames; digit c toggles its value every cycle.
    for (int c = 1; c <= 80; c++) begin
      cnib = 4'((c * 7) % 16);
      c_if.digits = cnib;
      tick();
      p = c % 4;
      i = (c / 4) % 4;
      f = c / 16;
      exp_an  = (p == 0) ? 4'hF : ~(4'b0001 << i);
      exp_seg = (p == 0) ? 8'hFF : ((i == 0 && (f == 2 || f == 3)) ? 8'hFF : 8'hC0);
      check($sformatf("blink_an_c%0d", c),  32'(a_if.an), 32'(exp_an));
      check($sformatf("blink_seg_c%0d", c), 32'(a_if.segment), 32'(exp_seg));
      check($sformatf("blink_ft_c%0d", c),  32'(a_if.frame_tick), 32'((c % 16) == 0));
      check($sformatf("one_an_c%0d", c),    32'(c_if.an), 32'h0);
      check($sformatf("one_ft_c%0d", c),    32'(c_if.frame_tick), 32'((c % 2) == 0));
      check($sformatf("one_seg_c%0d", c),   32'(c_if.segment), 32'({1'b1, hex_tab[cnib]}));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
